// File: rtl/cordic_sched.sv
// Round-robin front end that time-shares one pipelined CORDIC among NCHAN requesters.
// A channel tag travels alongside the CORDIC pipeline so each result is routed to its owner.
module cordic_sched #(
  parameter int unsigned CHW      = 2,
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned ZWIDTH   = 16,
  parameter int unsigned LATENCY  = 13,
  localparam int unsigned NCHAN   = 2 ** CHW
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NCHAN-1:0]          chan_mask,
  input  logic [NCHAN-1:0]          req_valid,
  input  logic [NCHAN*BITWIDTH-1:0] req_x,
  input  logic [NCHAN*BITWIDTH-1:0] req_y,
  input  logic [NCHAN*ZWIDTH-1:0]   req_z,
  output logic [NCHAN-1:0]          req_ready,
  output logic                      cordic_reset,
  output logic                      cordic_enable,
  output logic [BITWIDTH-1:0]       cordic_xi,
  output logic [BITWIDTH-1:0]       cordic_yi,
  output logic [ZWIDTH-1:0]         cordic_zi,
  input  logic [BITWIDTH-1:0]       cordic_xo,
  input  logic [BITWIDTH-1:0]       cordic_yo,
  input  logic [ZWIDTH-1:0]         cordic_zo,
  output logic [NCHAN-1:0]          res_valid,
  output logic [BITWIDTH-1:0]       res_x,
  output logic [BITWIDTH-1:0]       res_y,
  output logic [ZWIDTH-1:0]         res_z,
  output logic [CHW+4:0]            in_flight,
  output logic                      busy
);

  logic [1:0]                 rst_sync_q;
  logic [NCHAN-1:0]           eligible;
  logic [NCHAN-1:0]           grant;
  logic [CHW-1:0]             grant_idx;
  logic                       xfer;
  logic [CHW-1:0]             last_q;
  logic [BITWIDTH-1:0]        sel_x, sel_y;
  logic [ZWIDTH-1:0]          sel_z;
  logic [LATENCY:0]           tag_v_q;
  logic [LATENCY:0][CHW-1:0]  tag_ch_q;
  logic                       res_fire;
  logic [CHW+4:0]             in_flight_q, in_flight_d;

  // Assert immediately, release two edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign cordic_reset  = rst_sync_q[1];
  assign cordic_enable = enable;

  assign eligible = req_valid & chan_mask & {NCHAN{enable & ~cordic_reset}};

  // Search from last+1 upward, wrapping; the CHW-bit sum wraps modulo NCHAN.
  always_comb begin
    logic [CHW-1:0] idx;
    logic           found;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned d = 1; d <= NCHAN; d++) begin
      idx = last_q + CHW'(d);
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  assign sel_x = req_x[grant_idx*BITWIDTH +: BITWIDTH];
  assign sel_y = req_y[grant_idx*BITWIDTH +: BITWIDTH];
  assign sel_z = req_z[grant_idx*ZWIDTH +: ZWIDTH];

  always_comb begin
    res_valid = '0;
    if (tag_v_q[LATENCY] && enable) begin
      res_valid[tag_ch_q[LATENCY]] = 1'b1;
    end
  end

  assign res_fire    = |res_valid;
  assign in_flight_d = in_flight_q + (CHW+5)'(xfer) - (CHW+5)'(res_fire);

  // Everything below freezes with enable low so tags stay aligned with the CORDIC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cordic_xi   <= '0;
      cordic_yi   <= '0;
      cordic_zi   <= '0;
      tag_v_q     <= '0;
      tag_ch_q    <= '0;
      last_q      <= CHW'(NCHAN - 1);
      in_flight_q <= '0;
    end else if (enable) begin
      cordic_xi   <= xfer ? sel_x : '0;
      cordic_yi   <= xfer ? sel_y : '0;
      cordic_zi   <= xfer ? sel_z : '0;
      tag_v_q     <= {tag_v_q[LATENCY-1:0], xfer};
      tag_ch_q    <= {tag_ch_q[LATENCY-1:0], grant_idx};
      in_flight_q <= in_flight_d;
      if (xfer) begin
        last_q <= grant_idx;
      end
    end
  end

  assign res_x     = cordic_xo;
  assign res_y     = cordic_yo;
  assign res_z     = cordic_zo;
  assign in_flight = in_flight_q;
  assign busy      = |in_flight_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized bench for cordic_sched with a scoreboard and a behavioural CORDIC stand-in.
module tb_cordic_sched;

  localparam int CHW   = 2;
  localparam int NCHAN = 4;
  localparam int BW    = 16;
  localparam int ZW    = 16;
  localparam int LAT   = 13;
  localparam int SBN   = 4096;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [NCHAN-1:0]      chan_mask;
  logic [NCHAN-1:0]      req_valid;
  logic [NCHAN*BW-1:0]   req_x, req_y;
  logic [NCHAN*ZW-1:0]   req_z;
  logic [NCHAN-1:0]      req_ready;
  logic                  cordic_reset, cordic_enable;
  logic [BW-1:0]         cordic_xi, cordic_yi, cordic_xo, cordic_yo;
  logic [ZW-1:0]         cordic_zi, cordic_zo;
  logic [NCHAN-1:0]      res_valid;
  logic [BW-1:0]         res_x, res_y;
  logic [ZW-1:0]         res_z;
  logic [CHW+4:0]        in_flight;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_sched #(.CHW(CHW), .BITWIDTH(BW), .ZWIDTH(ZW), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_ready(req_ready), .cordic_reset(cordic_reset), .cordic_enable(cordic_enable),
    .cordic_xi(cordic_xi), .cordic_yi(cordic_yi), .cordic_zi(cordic_zi),
    .cordic_xo(cordic_xo), .cordic_yo(cordic_yo), .cordic_zo(cordic_zo),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .in_flight(in_flight), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rotation-mode CORDIC, 14 iterations, phase scaled so 32768 = pi.
  function automatic logic [47:0] cordic_ref(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z);
    int xs, ys, zs, xn, a;
    xs = int'($signed(x));
    ys = int'($signed(y));
    zs = int'($signed(z));
    for (int i = 0; i < 14; i++) begin
      a = $rtoi($atan(1.0 / (2.0 ** i)) * 32768.0 / 3.141592653589793 + 0.5);
      if (zs >= 0) begin
        xn = xs - (ys >>> i);
        ys = ys + (xs >>> i);
        zs = zs - a;
      end else begin
        xn = xs + (ys >>> i);
        ys = ys - (xs >>> i);
        zs = zs + a;
      end
      xs = xn;
    end
    return {xs[15:0], ys[15:0], zs[15:0]};
  endfunction

  // CORDIC stand-in: LAT register stages after the DUT's issue registers.
  logic [47:0] pipe [LAT];
  always @(posedge clock) begin
    if (cordic_reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (cordic_enable) begin
      pipe[0] <= cordic_ref(cordic_xi, cordic_yi, cordic_zi);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {cordic_xo, cordic_yo, cordic_zo} = pipe[LAT-1];

  // Enabled-cycle counter and reset-release counter.
  int en_cnt  = 0;
  int rst_cnt = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt = 0;
    end else begin
      if (rst_cnt < 2) rst_cnt++;
      if (enable) en_cnt++;
    end
  end

  // Scoreboard storage
  logic [CHW-1:0] sb_ch  [SBN];
  logic [47:0]    sb_res [SBN];
  int             sb_due [SBN];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pre_wr = 0;

  // Request side: reference arbiter, issue-stage model, scoreboard push.
  int               m_last = NCHAN - 1;
  logic [47:0]      iss = '0;
  logic [NCHAN-1:0] elig, exp_grant;
  int               gi;
  bit               found;
  logic [47:0]      smp;
  always @(negedge clock) begin
    chk("cordic_enable", 64'(cordic_enable), 64'(enable));
    chk("cordic_reset", 64'(cordic_reset), 64'(rst_cnt < 2));
    pre_wr = wr_ptr;
    if (!reset_n) begin
      chk("issue_in_reset", {16'h0, cordic_xi, cordic_yi, cordic_zi}, 64'h0);
      chk("ready_in_reset", 64'(req_ready), 64'h0);
      m_last = NCHAN - 1;
      iss    = '0;
    end else begin
      chk("issue_regs", {16'h0, cordic_xi, cordic_yi, cordic_zi}, {16'h0, iss});
      elig      = req_valid & chan_mask & {NCHAN{enable && rst_cnt >= 2}};
      exp_grant = '0;
      found     = 1'b0;
      gi        = 0;
      for (int k = 1; k <= NCHAN; k++) begin
        if (!found && elig[(m_last + k) % NCHAN]) begin
          found = 1'b1;
          gi    = (m_last + k) % NCHAN;
        end
      end
      if (found) exp_grant[gi] = 1'b1;
      chk("grant", 64'(req_ready), 64'(exp_grant));
      if (enable) iss = '0;
      if (found) begin
        smp = {req_x[gi*BW +: BW], req_y[gi*BW +: BW], req_z[gi*ZW +: ZW]};
        sb_ch[wr_ptr % SBN]  = gi[CHW-1:0];
        sb_res[wr_ptr % SBN] = cordic_ref(smp[47:32], smp[31:16], smp[15:0]);
        sb_due[wr_ptr % SBN] = en_cnt + LAT + 1;
        wr_ptr++;
        iss    = smp;
        m_last = gi;
      end
    end
  end

  // Result side: pop and compare when the head entry falls due.
  int               max_inflight = 0;
  logic [NCHAN-1:0] exp_v;
  always @(negedge clock) begin
    #1;
    exp_v = '0;
    if (!reset_n) begin
      chk("res_valid_in_reset", 64'(res_valid), 64'h0);
      chk("in_flight_in_reset", 64'(in_flight), 64'h0);
      rd_ptr = wr_ptr;
    end else begin
      chk("in_flight", 64'(in_flight), 64'(pre_wr - rd_ptr));
      chk("busy", 64'(busy), 64'(pre_wr != rd_ptr));
      if (rd_ptr != wr_ptr && sb_due[rd_ptr % SBN] == en_cnt && enable) begin
        exp_v[sb_ch[rd_ptr % SBN]] = 1'b1;
        chk("res_valid", 64'(res_valid), 64'(exp_v));
        chk("res_data", {16'h0, res_x, res_y, res_z}, {16'h0, sb_res[rd_ptr % SBN]});
        rd_ptr++;
      end else begin
        chk("res_valid_idle", 64'(res_valid), 64'h0);
      end
    end
    if (int'(in_flight) > max_inflight) max_inflight = int'(in_flight);
  end

  task automatic rand_data();
    req_x = {$urandom(), $urandom()};
    req_y = {$urandom(), $urandom()};
    req_z = {$urandom(), $urandom()};
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      rand_data();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    chan_mask = 4'hF;
    req_valid = 4'hF;
    rand_data();
    cyc(3);
    // Reset release with all channels requesting; pipeline fills to LAT+1.
    reset_n = 1'b1;
    cyc(40);
    chk("in_flight_saturation", 64'(max_inflight), 64'(LAT + 1));
    req_valid = '0;
    cyc(20);

    // Single sample on channel 2
    req_valid = 4'b0100;
    req_x[2*BW +: BW] = 16'h4000;
    req_y[2*BW +: BW] = 16'h0000;
    req_z[2*ZW +: ZW] = 16'h0000;
    cyc(1);
    req_valid = '0;
    cyc(20);

    // Freeze mid-stream
    req_valid = 4'b0011;
    cyc(10);
    enable = 1'b0;
    cyc(5);
    enable = 1'b1;
    cyc(25);
    req_valid = '0;
    cyc(20);

    // Mask channel 2 while one of its samples is in flight
    req_valid = 4'b0100;
    cyc(1);
    chan_mask = 4'b1011;
    req_valid = 4'hF;
    cyc(30);
    chan_mask = 4'hF;
    req_valid = '0;
    cyc(20);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom());
      chan_mask = 4'($urandom()) | 4'($urandom());
      enable    = ($urandom_range(0, 9) != 0);
      cyc(1);
    end
    enable    = 1'b1;
    chan_mask = 4'hF;
    req_valid = '0;
    cyc(20);

    // Reset with six samples in flight
    req_valid = 4'hF;
    cyc(6);
    req_valid = '0;
    cyc(2);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(25);

    for (int i = 0; i < 150; i++) begin
      req_valid = 4'($urandom());
      enable    = ($urandom_range(0, 7) != 0);
      cyc(1);
    end
    enable    = 1'b1;
    req_valid = '0;
    cyc(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler that time-shares one pipelined `cordic` instance among up to `NCHAN` requesters, such as per-channel NCO/mixer paths. It accepts one (x, y, z) sample per cycle from the granted channel and registers it into the CORDIC input. A channel-tag shift register runs in lockstep with the CORDIC pipeline, so each result returns on a shared bus with a one-hot valid naming its owner. It also generates the CORDIC's synchronous reset and pipeline enable.

## Interface
- `CHW`, 2: channel-index width; `NCHAN = 2**CHW` (default 4)
- `BITWIDTH`, 16: x/y width
- `ZWIDTH`, 16: phase width
- `LATENCY`, 13: CORDIC register stages, from its input register to its output
- `clock` in 1: sole clock
- `reset_n` in 1: one clock; reset is asynchronous and active-low
- `enable` in 1: global advance; low freezes the scheduler and the CORDIC
- `chan_mask` in NCHAN: per-channel enable; a masked channel is never granted
- `req_valid` in NCHAN: channel c has a sample
- `req_x`, `req_y` in NCHAN*BITWIDTH: flattened; channel c occupies bits [c*BITWIDTH +: BITWIDTH]
- `req_z` in NCHAN*ZWIDTH: flattened phase
- `req_ready` out NCHAN: one-hot grant (combinational)
- `cordic_reset` out 1: active-high reset to the CORDIC
- `cordic_enable` out 1: equals `enable`
- `cordic_xi`, `cordic_yi` out BITWIDTH; `cordic_zi` out ZWIDTH: registered issue stage
- `cordic_xo`, `cordic_yo` in BITWIDTH; `cordic_zo` in ZWIDTH: CORDIC results
- `res_valid` out NCHAN: one-hot result owner
- `res_x`, `res_y` out BITWIDTH; `res_z` out ZWIDTH: pass-through of the `cordic_*o` inputs
- `in_flight` out CHW+5: count of issued samples whose results have not yet emerged
- `busy` out 1: high when `in_flight` is not 0

## Operation
- **Eligibility:** channel c is eligible when `req_valid[c] & chan_mask[c] & enable` and `cordic_reset` is low.
- **Arbitration:** round-robin. Search starts at `last+1` and wraps modulo NCHAN. The lowest-distance eligible channel gets `req_ready`. At most one grant per cycle. No eligible channel means `req_ready` = 0.
- **Transfer and pointer:** a transfer occurs on `req_valid[c] & req_ready[c]`. `last` updates to c only when a transfer occurs.
- **Issue stage, on transfer:** `cordic_xi/yi/zi` load the channel's sample. Tag stage 0 loads {1, c}.
- **Issue stage, enable high with no transfer:** issue data loads 0 and tag stage 0 loads {0, x}.
- **Tag pipeline:** LATENCY+1 stages total (issue stage plus LATENCY). All stages shift only while `enable` is high.
- **Result output:** `res_valid` = one-hot(tag[LATENCY].ch) when `tag[LATENCY].v & enable`, else 0. Data is the raw `cordic_*o` values with no rescaling.
- **in_flight:** +1 per transfer, −1 per asserted `res_valid`. When both happen in the same cycle, the count is unchanged. Maximum value is LATENCY+1 and it never wraps.
- **Enable low:**
  - `req_ready` = 0 and `res_valid` = 0.
  - Issue regs, tags, `last` and `in_flight` hold.
  - Because `cordic_enable` = 0, the CORDIC holds too, so alignment is preserved when `enable` returns.
- **Fairness:** with `enable` high, a channel that stays eligible is granted within NCHAN cycles.
- **Masking:** clearing `chan_mask[c]` blocks new grants only. Samples already in flight for c still return.

## Timing
- **Reset assertion (`reset_n` low, async):**
  - Clears all tags, issue regs, `in_flight`, `res_valid` and `req_ready`.
  - Sets `last` = NCHAN−1, so channel 0 has first priority.
  - Asserts `cordic_reset` = 1 immediately.
- **Reset release:** `cordic_reset` deasserts through a 2-flop synchronizer, two rising edges after `reset_n` rises. Grants are blocked while `cordic_reset` is high.
- **Reset mid-operation:** all in-flight results are discarded, and no `res_valid` is produced for them afterward.
- **Latency:** a transfer at rising edge k produces `res_valid` (with data) in the cycle after edge k+LATENCY+1, counting only edges where `enable` is high.
- **Throughput:** one transfer per enabled cycle, sustained indefinitely.
- **Output registration:** `req_ready` and `res_*` are combinational from registers and the current `enable`. The `cordic_*i` outputs are registered.

## Test plan
- **Reset release:** reset_n low→high with all `req_valid` = 1 → no `req_ready` for 2 edges, then grants go 0,1,2,3,0… one per cycle; `in_flight` saturates at 14.
- **Single sample:** ch2 only, x=16'h4000, y=0, z=0 → exactly one `res_valid` = 4'b0100, 14 enabled cycles after the transfer; `res_*` match a golden CORDIC model; `busy` then falls.
- **Enable freeze:** continuous traffic on ch0/ch1, `enable` low for 5 cycles mid-stream → no `res_valid` while low; result order, owners and data identical to an unstalled run, shifted by 5 cycles.
- **Masking:** `chan_mask` = 4'b1011 with all valid → ch2 never granted; order 0,1,3,0…; an in-flight ch2 result issued before the mask change still returns.
- **Mid-flight reset:** 6 samples in flight, pulse `reset_n` low for 1 cycle → all outputs 0 at once, `in_flight` = 0, no stale `res_valid` afterward.
- **Simultaneous events:** transfer and `res_valid` in the same cycle → `in_flight` unchanged; round-robin resumes at `last+1`.
